// File: rtl/hamming_pkg.sv
// Shared helpers for the SECDED codec: code geometry and codeword bit-position mapping.
package hamming_pkg;

  // Smallest P with 2^P >= DATA_W + P + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < (data_w + p + 1)) p = p + 1;
    return p;
  endfunction

  function automatic int calc_cw_w(input int data_w);
    return data_w + calc_p(data_w) + 1;
  endfunction

  // Index 0 (overall parity) and power-of-two indices hold check bits.
  function automatic bit is_parity_pos(input int idx);
    return (idx == 0) || ((idx & (idx - 1)) == 0);
  endfunction

  // Codeword index that carries payload bit j.
  function automatic int data_pos(input int j);
    int idx;
    int cnt;
    idx = 0;
    cnt = 0;
    for (int i = 1; i < 128; i++) begin
      if (!is_parity_pos(i)) begin
        if ((cnt == j) && (idx == 0)) idx = i;
        cnt = cnt + 1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/hamming_parity_calc.sv
// Combinational syndrome generator: XOR of the indices of all set bits, plus overall parity.
module hamming_parity_calc #(
  parameter int CW_W = 13,
  parameter int P    = 4
) (
  input  logic [CW_W-1:0] cw_i,
  output logic [P-1:0]    syn_o,
  output logic            par_o
);

  always_comb begin
    syn_o = '0;
    for (int k = 0; k < P; k++) begin
      for (int i = 1; i < CW_W; i++) begin
        if (((i >> k) & 1) != 0) syn_o[k] = syn_o[k] ^ cw_i[i];
      end
    end
    par_o = ^cw_i;
  end

endmodule

// File: rtl/hamming_secded_codec.sv
// SECDED Hamming encoder (1-cycle) and decoder (2-stage pipeline) with saturating error counters.
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int CW_W   = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] enc_data,
  input  logic              enc_valid,
  output logic [CW_W-1:0]   enc_cw,
  output logic              enc_cw_valid,
  input  logic [CW_W-1:0]   dec_cw,
  input  logic              dec_valid,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_data_valid,
  output logic              dec_single_err,
  output logic              dec_double_err,
  output logic [P:0]        dec_err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corrected,
  output logic [CNT_W-1:0]  cnt_uncorrectable
);

  localparam logic [P-1:0] MAX_IDX = P'(CW_W - 1);

  logic [CW_W-1:0]   enc_raw, enc_full;
  logic [P-1:0]      enc_syn;
  logic              enc_par;
  logic [CW_W-1:0]   enc_cw_d, enc_cw_q;
  logic              enc_valid_d, enc_valid_q;

  logic [P-1:0]      dec_syn;
  logic              dec_par;
  logic              s1_valid_d, s1_valid_q;
  logic [P-1:0]      s1_syn_d, s1_syn_q;
  logic              s1_par_d, s1_par_q;
  logic [DATA_W-1:0] s1_payload_d, s1_payload_q;

  logic              s2_single, s2_double, s2_flip;
  logic [DATA_W-1:0] dec_data_d, dec_data_q;
  logic              dec_valid_d, dec_valid_q;
  logic              dec_single_d, dec_single_q;
  logic              dec_double_d, dec_double_q;
  logic [P:0]        dec_pos_d, dec_pos_q;

  logic [CNT_W-1:0]  cnt_corr_d, cnt_corr_q;
  logic [CNT_W-1:0]  cnt_unc_d, cnt_unc_q;

  // Encoder: scatter payload, then fill check bits from the syndrome of the partial word.
  always_comb begin
    enc_raw = '0;
    for (int j = 0; j < DATA_W; j++) enc_raw[data_pos(j)] = enc_data[j];
  end

  hamming_parity_calc #(.CW_W(CW_W), .P(P)) u_enc_pc (
    .cw_i  (enc_raw),
    .syn_o (enc_syn),
    .par_o (enc_par)
  );

  always_comb begin
    enc_full = enc_raw;
    for (int k = 0; k < P; k++) enc_full[1 << k] = enc_syn[k];
    enc_full[0] = enc_par ^ (^enc_syn);
    enc_cw_d    = enc_valid ? enc_full : '0;
    enc_valid_d = enc_valid;
  end

  // Decoder stage 1. Only the payload field is kept: the check bits are fully summarised by S and Q.
  hamming_parity_calc #(.CW_W(CW_W), .P(P)) u_dec_pc (
    .cw_i  (dec_cw),
    .syn_o (dec_syn),
    .par_o (dec_par)
  );

  always_comb begin
    s1_valid_d   = dec_valid;
    s1_syn_d     = dec_valid ? dec_syn : '0;
    s1_par_d     = dec_valid & dec_par;
    s1_payload_d = '0;
    for (int j = 0; j < DATA_W; j++) s1_payload_d[j] = dec_valid & dec_cw[data_pos(j)];
  end

  // Decoder stage 2: classify and correct.
  always_comb begin
    s2_single = s1_par_q && (s1_syn_q <= MAX_IDX);
    s2_double = ((s1_syn_q != '0) && !s1_par_q) || (s1_syn_q > MAX_IDX);
    s2_flip   = s2_single && (s1_syn_q != '0);

    dec_valid_d  = s1_valid_q;
    dec_single_d = s1_valid_q & s2_single;
    dec_double_d = s1_valid_q & s2_double;
    dec_pos_d    = (s1_valid_q && s2_single) ? {1'b0, s1_syn_q} : '0;
    dec_data_d   = '0;
    for (int j = 0; j < DATA_W; j++) begin
      dec_data_d[j] = s1_valid_q &
                      (s1_payload_q[j] ^ (s2_flip && (int'(s1_syn_q) == data_pos(j))));
    end
  end

  // Counters watch the registered flags; clear wins over increment.
  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_unc_d  = cnt_unc_q;
    if (cnt_clr) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
    end else begin
      if (dec_valid_q && dec_single_q && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (dec_valid_q && dec_double_q && (cnt_unc_q != '1))  cnt_unc_d  = cnt_unc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_cw_q     <= '0;
      enc_valid_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s1_payload_q <= '0;
      dec_data_q   <= '0;
      dec_valid_q  <= 1'b0;
      dec_single_q <= 1'b0;
      dec_double_q <= 1'b0;
      dec_pos_q    <= '0;
      cnt_corr_q   <= '0;
      cnt_unc_q    <= '0;
    end else begin
      enc_cw_q     <= enc_cw_d;
      enc_valid_q  <= enc_valid_d;
      s1_valid_q   <= s1_valid_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s1_payload_q <= s1_payload_d;
      dec_data_q   <= dec_data_d;
      dec_valid_q  <= dec_valid_d;
      dec_single_q <= dec_single_d;
      dec_double_q <= dec_double_d;
      dec_pos_q    <= dec_pos_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_unc_q    <= cnt_unc_d;
    end
  end

  assign enc_cw            = enc_cw_q;
  assign enc_cw_valid      = enc_valid_q;
  assign dec_data          = dec_data_q;
  assign dec_data_valid    = dec_valid_q;
  assign dec_single_err    = dec_single_q;
  assign dec_double_err    = dec_double_q;
  assign dec_err_pos       = dec_pos_q;
  assign cnt_corrected     = cnt_corr_q;
  assign cnt_uncorrectable = cnt_unc_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Randomised self-checking bench for hamming_secded_codec at DATA_W=8, CNT_W=16.
module tb_hamming_secded_codec;

  localparam int DW = 8;
  localparam int CW = 13;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic          single;
    logic          dbl;
    logic [4:0]    pos;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] enc_data = '0;
  logic          enc_valid = 1'b0;
  logic [CW-1:0] enc_cw;
  logic          enc_cw_valid;
  logic [CW-1:0] dec_cw = '0;
  logic          dec_valid = 1'b0;
  logic [DW-1:0] dec_data;
  logic          dec_data_valid, dec_single_err, dec_double_err;
  logic [4:0]    dec_err_pos;
  logic          cnt_clr = 1'b0;
  logic [15:0]   cnt_corrected, cnt_uncorrectable;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t dq[$];
  logic [15:0] m_corr = '0, m_unc = '0;
  logic pend_c = 1'b0, pend_u = 1'b0;

  hamming_secded_codec #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .enc_data(enc_data), .enc_valid(enc_valid), .enc_cw(enc_cw), .enc_cw_valid(enc_cw_valid),
    .dec_cw(dec_cw), .dec_valid(dec_valid), .dec_data(dec_data), .dec_data_valid(dec_data_valid),
    .dec_single_err(dec_single_err), .dec_double_err(dec_double_err), .dec_err_pos(dec_err_pos),
    .cnt_clr(cnt_clr), .cnt_corrected(cnt_corrected), .cnt_uncorrectable(cnt_uncorrectable)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  // Reference encoder built straight from the layout and parity rules.
  function automatic logic [CW-1:0] m_encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int j;
    logic p;
    c = '0;
    j = 0;
    for (int i = 1; i < CW; i++) if (!is_pow2(i)) begin c[i] = d[j]; j++; end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int i = 1; i < CW; i++) if ((i & (1 << k)) != 0) p ^= c[i];
      c[1 << k] = p;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [DW-1:0] m_extract(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CW; i++) if (!is_pow2(i)) begin d[j] = c[i]; j++; end
    return d;
  endfunction

  // Expected decoder result follows from how many bits were injected, not from a syndrome.
  task automatic mk_word(input int nflip, output logic [CW-1:0] cw, output exp_t e);
    logic [DW-1:0] d;
    int b0, b1;
    d  = DW'($urandom);
    b0 = $urandom_range(0, CW - 1);
    b1 = b0;
    while (b1 == b0) b1 = $urandom_range(0, CW - 1);
    cw = m_encode(d);
    e  = '{valid: 1'b1, data: d, single: 1'b0, dbl: 1'b0, pos: 5'd0};
    if (nflip == 1) begin
      cw[b0]   = ~cw[b0];
      e.single = 1'b1;
      e.pos    = 5'(b0);
    end else if (nflip == 2) begin
      cw[b0] = ~cw[b0];
      cw[b1] = ~cw[b1];
      e.dbl  = 1'b1;
      e.data = m_extract(cw);
    end
  endtask

  task automatic step(input logic ev, input logic [DW-1:0] ed, input logic dv,
                      input logic [CW-1:0] dcw, input exp_t e_in, input logic clr);
    exp_t e, o;
    e         = e_in;
    e.valid   = dv;
    enc_valid = ev;
    enc_data  = ed;
    dec_valid = dv;
    dec_cw    = dcw;
    cnt_clr   = clr;
    dq.push_back(e);
    if (clr) begin
      m_corr = '0;
      m_unc  = '0;
    end else begin
      if (pend_c && m_corr != 16'hFFFF) m_corr = m_corr + 16'd1;
      if (pend_u && m_unc != 16'hFFFF)  m_unc  = m_unc + 16'd1;
    end
    @(posedge clk);
    #1;
    chk("enc_valid", 64'(enc_cw_valid), 64'(ev));
    if (ev) chk("enc_cw", 64'(enc_cw), 64'(m_encode(ed)));
    o = dq.pop_front();
    chk("dec_valid", 64'(dec_data_valid), 64'(o.valid));
    chk("single", 64'(dec_single_err), 64'(o.valid & o.single));
    chk("double", 64'(dec_double_err), 64'(o.valid & o.dbl));
    chk("err_pos", 64'(dec_err_pos), o.valid ? 64'(o.pos) : 64'd0);
    if (o.valid) chk("dec_data", 64'(dec_data), 64'(o.data));
    chk("cnt_corr", 64'(cnt_corrected), 64'(m_corr));
    chk("cnt_unc", 64'(cnt_uncorrectable), 64'(m_unc));
    pend_c = o.valid & o.single;
    pend_u = o.valid & o.dbl;
  endtask

  task automatic idle(input int n);
    exp_t z;
    z = '0;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, z, 1'b0);
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    dq.delete();
    dq.push_back(z);
    m_corr = '0;
    m_unc  = '0;
    pend_c = 1'b0;
    pend_u = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_encv"}, 64'(enc_cw_valid), 64'd0);
    chk({tag, "_enc"}, 64'(enc_cw), 64'd0);
    chk({tag, "_decv"}, 64'(dec_data_valid), 64'd0);
    chk({tag, "_data"}, 64'(dec_data), 64'd0);
    chk({tag, "_flags"}, 64'({dec_single_err, dec_double_err}), 64'd0);
    chk({tag, "_pos"}, 64'(dec_err_pos), 64'd0);
    chk({tag, "_cntc"}, 64'(cnt_corrected), 64'd0);
    chk({tag, "_cntu"}, 64'(cnt_uncorrectable), 64'd0);
  endtask

  initial begin
    logic [CW-1:0] cw;
    exp_t e;
    int nf;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rst = 1'b0;
    model_reset();

    // Known-answer vectors around payload 0xA5 (codeword 0x144E).
    step(1'b1, 8'hA5, 1'b1, 13'h140E, '{1'b1, 8'hA5, 1'b1, 1'b0, 5'd6}, 1'b0);
    chk("enc_a5", 64'(enc_cw), 64'h144E);
    step(1'b0, '0, 1'b1, 13'h144F, '{1'b1, 8'hA5, 1'b1, 1'b0, 5'd0}, 1'b0);
    step(1'b0, '0, 1'b1, 13'h1466, '{1'b1, 8'hA6, 1'b0, 1'b1, 5'd0}, 1'b0);
    step(1'b0, '0, 1'b1, 13'h144E, '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd0}, 1'b0);
    idle(2);
    chk("kat_cntc", 64'(cnt_corrected), 64'd2);
    chk("kat_cntu", 64'(cnt_uncorrectable), 64'd1);

    // Back-to-back random decode with concurrent random encode.
    for (int i = 0; i < 600; i++) begin
      nf = $urandom_range(0, 2);
      mk_word(nf, cw, e);
      step(($urandom_range(0, 3) != 0), DW'($urandom), 1'b1, cw, e, 1'b0);
    end
    idle(3);

    // Saturation: clear, then 0xFFFE single-error words, then 3 more.
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 16'hFFFE; i++) begin
      mk_word(1, cw, e);
      step(1'b0, '0, 1'b1, cw, e, 1'b0);
    end
    idle(2);
    chk("cnt_pre_sat", 64'(cnt_corrected), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      mk_word(1, cw, e);
      step(1'b0, '0, 1'b1, cw, e, 1'b0);
    end
    idle(2);
    chk("cnt_sat", 64'(cnt_corrected), 64'hFFFF);

    // Clear in the same cycle the counter would otherwise increment.
    mk_word(1, cw, e);
    step(1'b0, '0, 1'b1, cw, e, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    chk("cnt_clr_prio", 64'(cnt_corrected), 64'd0);

    // Asynchronous reset mid-stream with words in flight.
    for (int i = 0; i < 8; i++) begin
      mk_word(1 + (i % 2), cw, e);
      step(1'b1, DW'($urandom), 1'b1, cw, e, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(3);
    mk_word(1, cw, e);
    step(1'b1, 8'h3C, 1'b1, cw, e, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
